pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the core's four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB. It generates per-stage hold (stall) and bubble (flush) controls; flush drives each stage register's syn_reset input. It resolves load-use hazards, taken branches, traps, data-memory wait states and multicycle MUL/DIV waits through a small FSM. It also keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID
id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes rd
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_mdu_start  in  1  EX holds a multicycle MUL/DIV op
mdu_done  in  1  MUL/DIV result valid this cycle
mem_req  in  1  MEM stage is issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
trap  in  1  exception or interrupt commit; flush the whole pipeline
cnt_clear  in  1  synchronous clear of both counters
pc_stall  out  1  hold the PC
stall  out  4  per-stage hold; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB
flush  out  4  per-stage bubble, same bit order; connects to syn_reset
stall_cycles  out  CNT_W  cycles with any stall bit set
flush_events  out  CNT_W  cycles with any flush bit set

Behaviour:
- Single clock, clk. reset is asynchronous and active-low.
- While reset is low: state = RUN, both counters = 0, and pc_stall, stall and flush are forced to 0.
- pc_stall, stall and flush are combinational (Mealy) functions of state and inputs, so they apply in the same cycle as the cause. The counters are registered.
- Priority, highest first: trap > memory wait > MDU wait > branch > load-use.
- FSM states: RUN, MEM_WAIT, MDU_WAIT.
- trap, in any state: flush = 4'b1111, stall = 0, pc_stall = 0; next state RUN. Any in-progress wait is abandoned.
- RUN with mem_req=1 and mem_ready=0: pc_stall = 1, stall = 4'b0111, flush = 4'b1000; next state MEM_WAIT.
- MEM_WAIT: same outputs while mem_ready=0. With mem_ready=1: all outputs 0, next state RUN.
- RUN with ex_mdu_start=1 and mdu_done=0, and no memory wait: pc_stall = 1, stall = 4'b0011, flush = 4'b0100; next state MDU_WAIT.
- RUN with ex_mdu_start=1 and mdu_done=1: no stall.
- MDU_WAIT: same outputs until mdu_done=1. That cycle: all outputs 0, next state RUN.
- MDU_WAIT with mem_req=1 and mem_ready=0: the MEM stage already holds a bubble, so the memory request is ignored; stay in MDU_WAIT.
- Branch (RUN, no higher cause): flush = 4'b0011, no stall. A branch and a load-use in the same cycle resolve as a branch only; the ID instruction is discarded.
- Load-use (RUN, no higher cause) is detected when all of the following hold:
  - ex_is_load = 1, ex_reg_write = 1 and ex_rd != 0;
  - (id_uses_rs1 = 1 and id_rs1 == ex_rd) or (id_uses_rs2 = 1 and id_rs2 == ex_rd).
- Load-use response: pc_stall = 1, stall = 4'b0001, flush = 4'b0010, for exactly one cycle. The hazard naturally clears on the next cycle.
- A stall bit and a flush bit are never both set for the same stage.
- Counters, evaluated every cycle:
  - stall_cycles increments by 1 when pc_stall or any stall bit is set;
  - flush_events increments by 1 when any flush bit is set;
  - both saturate at 2^CNT_W-1 and do not wrap;
  - cnt_clear zeroes both counters and takes precedence over an increment in the same cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum: RUN, MEM_WAIT, MDU_WAIT;
  - stage index constants: STG_IF_ID=0, STG_ID_EX=1, STG_EX_MEM=2, STG_MEM_WB=3;
  - NUM_STAGES=4.
- One sub-module, sat_counter (parameter WIDTH; ports clk, reset, clr, inc, q), instantiated twice.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_stall=1, stall=0001, flush=0010; stall_cycles 0->1.
- Load with ex_rd=0 and matching rs1=0 -> all outputs 0, counters unchanged.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> stall=0111 and flush=1000 for 3 cycles, then all 0 in the ready cycle; state back to RUN; stall_cycles=3.
- MDU wait: ex_mdu_start=1, mdu_done after 4 cycles -> stall=0011, flush=0100 for 4 cycles, then 0; a concurrent ex_branch_taken during the wait is ignored.
- Trap in MEM_WAIT on cycle 2 -> flush=1111 that cycle, state RUN next cycle; flush_events increments by 1.
- Saturation and clear:
  - CNT_W=4 with 20 consecutive stall cycles -> stall_cycles holds at 15;
  - cnt_clear asserted together with a stall -> counter reads 0;
  - reset pulsed low mid-wait -> all outputs 0 immediately, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and stage indices for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_e;

  localparam int NUM_STAGES = 4;

  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {WIDTH{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - per-stage stall/flush sequencer with stall and flush performance counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  trap,
  input  logic                  cnt_clear,
  output logic                  pc_stall,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  state_e                state_q;
  state_e                state_d;
  logic                  pc_stall_c;
  logic [NUM_STAGES-1:0] stall_c;
  logic [NUM_STAGES-1:0] flush_c;
  logic                  load_use;

  assign load_use = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    pc_stall_c = 1'b0;
    stall_c    = '0;
    flush_c    = '0;

    if (trap) begin
      flush_c = '1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            pc_stall_c             = 1'b1;
            stall_c[STG_IF_ID]     = 1'b1;
            stall_c[STG_ID_EX]     = 1'b1;
            stall_c[STG_EX_MEM]    = 1'b1;
            flush_c[STG_MEM_WB]    = 1'b1;
            state_d                = MEM_WAIT;
          end else if (ex_mdu_start && !mdu_done) begin
            pc_stall_c             = 1'b1;
            stall_c[STG_IF_ID]     = 1'b1;
            stall_c[STG_ID_EX]     = 1'b1;
            flush_c[STG_EX_MEM]    = 1'b1;
            state_d                = MDU_WAIT;
          end else if (ex_branch_taken) begin
            // wrong-path IF and ID instructions are squashed, even a load-use victim
            flush_c[STG_IF_ID]     = 1'b1;
            flush_c[STG_ID_EX]     = 1'b1;
          end else if (load_use) begin
            pc_stall_c             = 1'b1;
            stall_c[STG_IF_ID]     = 1'b1;
            flush_c[STG_ID_EX]     = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            pc_stall_c             = 1'b1;
            stall_c[STG_IF_ID]     = 1'b1;
            stall_c[STG_ID_EX]     = 1'b1;
            stall_c[STG_EX_MEM]    = 1'b1;
            flush_c[STG_MEM_WB]    = 1'b1;
          end else begin
            state_d                = RUN;
          end
        end
        MDU_WAIT: begin
          // MEM already carries a bubble here, so memory requests are not honoured
          if (!mdu_done) begin
            pc_stall_c             = 1'b1;
            stall_c[STG_IF_ID]     = 1'b1;
            stall_c[STG_ID_EX]     = 1'b1;
            flush_c[STG_EX_MEM]    = 1'b1;
          end else begin
            state_d                = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_stall = reset ? pc_stall_c : 1'b0;
  assign stall    = reset ? stall_c    : '0;
  assign flush    = reset ? flush_c    : '0;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clear),
    .inc   (pc_stall || (|stall)),
    .q     (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clear),
    .inc   (|flush),
    .q     (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_reg_write;
  logic          ex_branch_taken, ex_mdu_start, mdu_done, mem_req, mem_ready;
  logic          trap, cnt_clear;
  logic          pc_stall;
  logic [3:0]    stall, flush;
  logic [CW-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ready(mem_ready), .trap(trap), .cnt_clear(cnt_clear),
    .pc_stall(pc_stall), .stall(stall), .flush(flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // Reference: which wait the pipeline is sitting in, and counter values as integers.
  bit m_in_mem_wait, m_in_mdu_wait;
  int m_stall_cnt, m_flush_cnt;

  always @(negedge clk) begin
    bit       e_pc;
    bit [3:0] e_st, e_fl;
    bit       mem_hold, mdu_hold, hazard;
    e_pc = 0; e_st = 0; e_fl = 0; mem_hold = 0; mdu_hold = 0;
    if (!reset) begin
      m_in_mem_wait = 0; m_in_mdu_wait = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      hazard = ex_is_load && ex_reg_write && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (!trap) begin
        mem_hold = m_in_mem_wait ? !mem_ready : (!m_in_mdu_wait && mem_req && !mem_ready);
        mdu_hold = !mem_hold && (m_in_mdu_wait ? !mdu_done
                                 : (!m_in_mem_wait && ex_mdu_start && !mdu_done));
      end
      if (trap) e_fl = 4'b1111;
      else if (mem_hold) begin e_pc = 1; e_st = 4'b0111; e_fl = 4'b1000; end
      else if (mdu_hold) begin e_pc = 1; e_st = 4'b0011; e_fl = 4'b0100; end
      else if (!m_in_mem_wait && !m_in_mdu_wait) begin
        if (ex_branch_taken) e_fl = 4'b0011;
        else if (hazard) begin e_pc = 1; e_st = 4'b0001; e_fl = 4'b0010; end
      end
    end
    checks++;
    if ({pc_stall, stall, flush} !== {e_pc, e_st, e_fl}) begin
      errors++;
      $display("FAIL model_outputs t=%0t got pc=%b st=%b fl=%b want pc=%b st=%b fl=%b",
               $time, pc_stall, stall, flush, e_pc, e_st, e_fl);
    end
    checks++;
    if (stall_cycles !== CW'(m_stall_cnt) || flush_events !== CW'(m_flush_cnt)) begin
      errors++;
      $display("FAIL model_counters t=%0t got %0d/%0d want %0d/%0d",
               $time, stall_cycles, flush_events, m_stall_cnt, m_flush_cnt);
    end
    checks++;
    if ((stall & flush) !== 4'b0) begin
      errors++;
      $display("FAIL stall_flush_overlap t=%0t stall=%b flush=%b", $time, stall, flush);
    end
    if (reset) begin
      if (cnt_clear) begin m_stall_cnt = 0; m_flush_cnt = 0; end
      else begin
        if ((e_pc || e_st != 0) && m_stall_cnt < 15) m_stall_cnt++;
        if (e_fl != 0 && m_flush_cnt < 15) m_flush_cnt++;
      end
      m_in_mem_wait = mem_hold;
      m_in_mdu_wait = mdu_hold;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic chk_out(input string name, input logic p, input logic [3:0] s, input logic [3:0] f);
    chk({name, "_pc"}, 32'(pc_stall), 32'(p));
    chk({name, "_stall"}, 32'(stall), 32'(s));
    chk({name, "_flush"}, 32'(flush), 32'(f));
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_rd = 0;
    ex_is_load = 0; ex_reg_write = 0; ex_branch_taken = 0; ex_mdu_start = 0;
    mdu_done = 0; mem_req = 0; mem_ready = 0; trap = 0; cnt_clear = 0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk_out("reset", 0, 4'b0000, 4'b0000);
    chk("reset_cnt", 32'({stall_cycles, flush_events}), 0);
    cyc(); cyc();
    reset = 1'b1;

    cyc();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1 chk_out("load_use", 1, 4'b0001, 4'b0010);
    chk("load_use_cnt_before", 32'(stall_cycles), 0);
    cyc(); idle();
    #1 chk_out("load_use_over", 0, 4'b0000, 4'b0000);
    chk("load_use_cnt_after", 32'(stall_cycles), 1);

    cyc();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #1 chk_out("load_x0", 0, 4'b0000, 4'b0000);
    cyc(); idle();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 7; id_uses_rs2 = 1;
    #1 chk_out("load_use_rs2", 1, 4'b0001, 4'b0010);
    cyc(); idle();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_rs1 = 7;
    #1 chk_out("rs1_not_used", 0, 4'b0000, 4'b0000);
    chk("cnt_after_loads", 32'(stall_cycles), 2);

    cyc(); idle(); cnt_clear = 1;
    cyc(); idle();
    #1 chk("cleared", 32'({stall_cycles, flush_events}), 0);

    for (int i = 0; i < 3; i++) begin
      mem_req = 1; mem_ready = 0;
      #1 chk_out("mem_wait", 1, 4'b0111, 4'b1000);
      cyc();
    end
    mem_ready = 1;
    #1 chk_out("mem_ready", 0, 4'b0000, 4'b0000);
    cyc(); idle();
    #1 chk("mem_stall_cnt", 32'(stall_cycles), 3);
    chk("mem_flush_cnt", 32'(flush_events), 3);

    for (int i = 0; i < 4; i++) begin
      ex_mdu_start = 1; ex_branch_taken = (i == 2);
      mem_req = (i == 1); mem_ready = 0;
      #1 chk_out("mdu_wait", 1, 4'b0011, 4'b0100);
      cyc(); idle();
    end
    ex_mdu_start = 1; mdu_done = 1;
    #1 chk_out("mdu_done", 0, 4'b0000, 4'b0000);
    cyc(); idle();
    #1 chk("mdu_stall_cnt", 32'(stall_cycles), 7);

    mem_req = 1;
    cyc(); mem_req = 1; trap = 1;
    #1 chk_out("trap", 0, 4'b0000, 4'b1111);
    cyc(); idle();
    #1 chk_out("after_trap_run", 0, 4'b0000, 4'b0000);
    chk("trap_flush_cnt", 32'(flush_events), 9);

    ex_branch_taken = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    #1 chk_out("branch_over_load", 0, 4'b0000, 4'b0011);
    cyc(); idle();
    ex_mdu_start = 1; mdu_done = 1;
    #1 chk_out("mdu_immediate", 0, 4'b0000, 4'b0000);

    cyc(); idle();
    for (int i = 0; i < 20; i++) begin
      mem_req = 1;
      cyc();
    end
    #1 chk("sat_stall", 32'(stall_cycles), 15);
    chk("sat_flush", 32'(flush_events), 15);
    mem_ready = 1;
    cyc(); idle();
    mem_req = 1; cnt_clear = 1;
    #1 chk_out("clear_with_stall", 1, 4'b0111, 4'b1000);
    cyc(); idle(); mem_ready = 1;
    #1 chk("clear_wins", 32'({stall_cycles, flush_events}), 0);

    cyc(); idle(); ex_mdu_start = 1;
    cyc(); ex_mdu_start = 1;
    cyc(); ex_mdu_start = 1;
    reset = 1'b0;
    #1 chk_out("reset_mid_wait", 0, 4'b0000, 4'b0000);
    chk("reset_mid_cnt", 32'({stall_cycles, flush_events}), 0);
    cyc(); idle();
    reset = 1'b1;
    cyc();
    #1 chk_out("run_after_reset", 0, 4'b0000, 4'b0000);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
